// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS execution core:
// opcodes, R-type functs, ALU control codes and the link register.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/mips_exec_alu.sv
// 32-bit ALU: add, sub, and, or, signed slt; unassigned control
// codes yield zero.
module mips_exec_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_ctl,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (alu_ctl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS decode, ALU, next-PC logic and PC register.
// Define MIPS_EXEC_JR_EN to decode R-type jr.
module mips_exec_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_new,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  wr_addr,
    output logic        reg_we,
    output logic [31:0] wr_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] simm;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    logic        alu_src;
    alu_op_e     alu_ctl;
    logic        is_beq;
    logic        is_bne;
    logic        is_jump;
    logic        is_jal;
    logic        is_lw;
    logic        is_jr;

    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];
    assign simm    = {{16{instr[15]}}, instr[15:0]};

    assign pc4       = pc_q + 32'd4;
    assign pc8       = pc_q + 32'd8;
    assign br_target = pc4 + {simm[29:0], 2'b00};
    assign j_target  = {4'b0000, instr[25:0], 2'b00};

    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wr_addr = instr[20:16];
        alu_src = 1'b0;
        alu_ctl = ALU_ADD;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jump = 1'b0;
        is_jal  = 1'b0;
        is_lw   = 1'b0;
        is_jr   = 1'b0;
        case (op)
            OP_RTYPE: begin
                wr_addr = instr[15:11];
                reg_we  = 1'b1;
                case (funct)
                    FN_ADD: alu_ctl = ALU_ADD;
                    FN_SUB: alu_ctl = ALU_SUB;
                    FN_AND: alu_ctl = ALU_AND;
                    FN_OR:  alu_ctl = ALU_OR;
                    FN_SLT: alu_ctl = ALU_SLT;
`ifdef MIPS_EXEC_JR_EN
                    FN_JR: begin
                        reg_we = 1'b0;
                        is_jr  = 1'b1;
                    end
`endif
                    default: reg_we = 1'b0;
                endcase
            end
            OP_LW: begin
                reg_we  = 1'b1;
                alu_src = 1'b1;
                is_lw   = 1'b1;
            end
            OP_SW: begin
                mem_we  = 1'b1;
                alu_src = 1'b1;
            end
            OP_BEQ: begin
                alu_ctl = ALU_SUB;
                is_beq  = 1'b1;
            end
            OP_BNE: begin
                alu_ctl = ALU_SUB;
                is_bne  = 1'b1;
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                alu_src = 1'b1;
            end
            OP_ANDI: begin
                reg_we  = 1'b1;
                alu_src = 1'b1;
                alu_ctl = ALU_AND;
            end
            OP_J: is_jump = 1'b1;
            OP_JAL: begin
                is_jump = 1'b1;
                is_jal  = 1'b1;
                reg_we  = 1'b1;
                wr_addr = REG_RA;
            end
            default: ;
        endcase
    end

    assign alu_b = alu_src ? simm : rt_data;

    mips_exec_alu u_alu (
        .a       (rs_data),
        .b       (alu_b),
        .alu_ctl (alu_ctl),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    always_comb begin
        pc_d = pc4;
        if (is_jump)
            pc_d = j_target;
        else if (is_jr)
            pc_d = rs_data;
        else if ((is_beq && alu_zero) || (is_bne && !alu_zero))
            pc_d = br_target;
    end

    always_comb begin
        wr_data = alu_result;
        if (is_jal)
            wr_data = pc8;
        else if (is_lw)
            wr_data = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc        = pc_q;
    assign pc_new    = pc_d;
    assign mem_addr  = alu_result;
    assign mem_wdata = rt_data;

endmodule

// File: tb/tb_mips_exec_core.sv
// Directed-vector bench for mips_exec_core with hand-computed results.
// Build with MIPS_EXEC_JR_EN defined to exercise jr.
module tb_mips_exec_core;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_new;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  wr_addr;
    logic        reg_we;
    logic [31:0] wr_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    int passed = 0;
    int total  = 0;

    mips_exec_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .pc_new    (pc_new),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .wr_addr   (wr_addr),
        .reg_we    (reg_we),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] rs,
                         input logic [31:0] rt);
        instr   = i;
        rs_data = rs;
        rt_data = rt;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        instr     = 32'd0;
        rs_data   = 32'd0;
        rt_data   = 32'd0;
        mem_rdata = 32'd0;

        // reset asserted between clock edges
        #20 reset = 1'b1;
        #1;
        chk("reset_pc_async", pc, 32'h0);
        drive(32'h0022_1820, 32'd5, 32'd7);
        chk("reset_decode_we", {31'd0, reg_we}, 32'd1);
        chk("reset_decode_wd", wr_data, 32'd12);
        chk("reset_pc_hold", pc, 32'h0);
        drive(32'h0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 4; i++) begin
            chk("nop_pc", pc, 32'(4 * i));
            chk("nop_reg_we", {31'd0, reg_we}, 32'd0);
            tick();
        end

        // R-type
        drive(32'h0022_1820, 32'd5, 32'd7);
        chk("add_rs_addr", {27'd0, rs_addr}, 32'd1);
        chk("add_rt_addr", {27'd0, rt_addr}, 32'd2);
        chk("add_reg_we", {31'd0, reg_we}, 32'd1);
        chk("add_wr_addr", {27'd0, wr_addr}, 32'd3);
        chk("add_wr_data", wr_data, 32'd12);
        chk("add_mem_we", {31'd0, mem_we}, 32'd0);
        drive(32'h0022_1822, 32'd5, 32'd7);
        chk("sub_wr_data", wr_data, 32'hFFFF_FFFE);
        drive(32'h0022_182A, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg_lt", wr_data, 32'd1);
        drive(32'h0022_182A, 32'd1, 32'hFFFF_FFFF);
        chk("slt_pos_gt", wr_data, 32'd0);
        drive(32'h0022_1824, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("and_wr_data", wr_data, 32'h00F0_1200);
        drive(32'h0022_1825, 32'hF000_0001, 32'h0000_0F00);
        chk("or_wr_data", wr_data, 32'hF000_0F01);
        drive(32'h0022_1821, 32'd5, 32'd7);
        chk("badfn_reg_we", {31'd0, reg_we}, 32'd0);

        // memory ops
        mem_rdata = 32'hDEAD_BEEF;
        drive(32'h8C22_FFFC, 32'h100, 32'h0);
        chk("lw_mem_addr", mem_addr, 32'hFC);
        chk("lw_wr_addr", {27'd0, wr_addr}, 32'd2);
        chk("lw_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("lw_reg_we", {31'd0, reg_we}, 32'd1);
        chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
        drive(32'hAC22_0008, 32'h100, 32'h55);
        chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw_mem_addr", mem_addr, 32'h108);
        chk("sw_mem_wdata", mem_wdata, 32'h55);
        chk("sw_reg_we", {31'd0, reg_we}, 32'd0);

        // immediates
        drive(32'h2022_FFFF, 32'd10, 32'd0);
        chk("addi_wr_data", wr_data, 32'd9);
        chk("addi_wr_addr", {27'd0, wr_addr}, 32'd2);
        drive(32'h3022_8001, 32'hFFFF_00FF, 32'd0);
        chk("andi_sext", wr_data, 32'hFFFF_0001);

        // move to pc=0x40 with j
        drive(32'h0800_0010, 32'd0, 32'd0);
        chk("j_pc_new", pc_new, 32'h40);
        chk("j_reg_we", {31'd0, reg_we}, 32'd0);
        tick();
        chk("j_pc", pc, 32'h40);

        drive(32'h1022_0003, 32'd9, 32'd9);
        chk("beq_taken", pc_new, 32'h50);
        chk("beq_reg_we", {31'd0, reg_we}, 32'd0);
        drive(32'h1022_0003, 32'd9, 32'd8);
        chk("beq_not", pc_new, 32'h44);
        drive(32'h1422_0003, 32'd9, 32'd9);
        chk("bne_not", pc_new, 32'h44);
        drive(32'h1422_0003, 32'd9, 32'd8);
        chk("bne_taken", pc_new, 32'h50);
        drive(32'h1022_FFFF, 32'd3, 32'd3);
        chk("beq_back", pc_new, 32'h40);

        // move to pc=0x20
        drive(32'h0800_0008, 32'd0, 32'd0);
        tick();
        chk("j2_pc", pc, 32'h20);

        drive(32'h0C00_0010, 32'd0, 32'd0);
        chk("jal_pc_new", pc_new, 32'h40);
        chk("jal_wr_addr", {27'd0, wr_addr}, 32'd31);
        chk("jal_wr_data", wr_data, 32'h28);
        chk("jal_reg_we", {31'd0, reg_we}, 32'd1);
        chk("jal_mem_we", {31'd0, mem_we}, 32'd0);

        drive(32'h0020_0008, 32'h80, 32'd0);
`ifdef MIPS_EXEC_JR_EN
        chk("jr_pc_new", pc_new, 32'h80);
`else
        chk("jr_off_pc_new", pc_new, 32'h24);
`endif
        chk("jr_reg_we", {31'd0, reg_we}, 32'd0);
        chk("jr_mem_we", {31'd0, mem_we}, 32'd0);

        drive(32'hFC00_0000, 32'd1, 32'd2);
        chk("ill_pc_new", pc_new, 32'h24);
        chk("ill_reg_we", {31'd0, reg_we}, 32'd0);
        chk("ill_mem_we", {31'd0, mem_we}, 32'd0);

        // reset again from a nonzero pc, between edges
        reset = 1'b1;
        #1;
        chk("reset2_pc", pc, 32'h0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
